// File: rtl/regfile_2r1w_param.sv
// Parametrised 2-read/1-write register file with registered read ports.
// Optional write-to-read bypass and hardwired-zero register 0.
module regfile_2r1w_param #(
    parameter int DW      = 4,
    parameter int AW      = 2,
    parameter int ZERO_R0 = 0,
    parameter int BYPASS  = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] rs,
    input  logic [AW-1:0] rt,
    input  logic          re,
    input  logic [AW-1:0] rw,
    input  logic [DW-1:0] dw,
    input  logic          rwe,
    output logic [DW-1:0] crs,
    output logic [DW-1:0] crt,
    output logic          wcol
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] mem [DEPTH];
    logic          wr_en;
    logic          hit;
    logic [DW-1:0] next_s;
    logic [DW-1:0] next_t;

    // A write aimed at a hardwired-zero register 0 is silently dropped.
    assign wr_en = rwe && !((ZERO_R0 != 0) && (rw == '0));
    assign hit   = wr_en && ((rw == rs) || (rw == rt));

    always_comb begin
        next_s = mem[rs];
        if ((BYPASS != 0) && rwe && (rw == rs)) next_s = dw;
        if ((ZERO_R0 != 0) && (rs == '0))       next_s = '0;
    end

    always_comb begin
        next_t = mem[rt];
        if ((BYPASS != 0) && rwe && (rw == rt)) next_t = dw;
        if ((ZERO_R0 != 0) && (rt == '0))       next_t = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[rw] <= dw;
        end
    end

    // Read registers hold their value whenever re is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crs  <= '0;
            crt  <= '0;
            wcol <= 1'b0;
        end else if (re) begin
            crs  <= next_s;
            crt  <= next_t;
            wcol <= hit;
        end
    end

endmodule

// File: tb/tb_regfile_2r1w_param.sv
// Scoreboard bench: four register-file configurations checked against queued expectations.
module tb_regfile_2r1w_param;

    typedef struct packed {
        logic [31:0] crs;
        logic [31:0] crt;
        logic        wcol;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [1:0]  rs, rt, rw;
    logic [3:0]  dw;
    logic        re, rwe;
    logic [3:0]  crs_a, crt_a, crs_b, crt_b, crs_c, crt_c;
    logic        wcol_a, wcol_b, wcol_c;
    logic [4:0]  rs32, rt32, rw32;
    logic [31:0] dw32, crs32, crt32;
    logic        re32, rwe32, wcol32;

    int   checks = 0;
    int   errors = 0;
    exp_t q [4][$];
    logic [31:0] mmem [32];
    exp_t mout;

    regfile_2r1w_param dut_a (
        .clk(clk), .rst_n(rst_n), .rs(rs), .rt(rt), .re(re), .rw(rw), .dw(dw),
        .rwe(rwe), .crs(crs_a), .crt(crt_a), .wcol(wcol_a)
    );

    regfile_2r1w_param #(.BYPASS(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .rs(rs), .rt(rt), .re(re), .rw(rw), .dw(dw),
        .rwe(rwe), .crs(crs_b), .crt(crt_b), .wcol(wcol_b)
    );

    regfile_2r1w_param #(.ZERO_R0(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .rs(rs), .rt(rt), .re(re), .rw(rw), .dw(dw),
        .rwe(rwe), .crs(crs_c), .crt(crt_c), .wcol(wcol_c)
    );

    regfile_2r1w_param #(.DW(32), .AW(5)) dut_w (
        .clk(clk), .rst_n(rst_n), .rs(rs32), .rt(rt32), .re(re32), .rw(rw32), .dw(dw32),
        .rwe(rwe32), .crs(crs32), .crt(crt32), .wcol(wcol32)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic exp_t mk(input logic [31:0] s, input logic [31:0] t, input logic w);
        exp_t r;
        r.crs  = s;
        r.crt  = t;
        r.wcol = w;
        return r;
    endfunction

    function automatic exp_t obs(input int k);
        exp_t r;
        case (k)
            0:       r = mk({28'd0, crs_a}, {28'd0, crt_a}, wcol_a);
            1:       r = mk({28'd0, crs_b}, {28'd0, crt_b}, wcol_b);
            2:       r = mk({28'd0, crs_c}, {28'd0, crt_c}, wcol_c);
            default: r = mk(crs32, crt32, wcol32);
        endcase
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] a_rs, input logic [1:0] a_rt, input logic a_re,
                         input logic [1:0] a_rw, input logic [3:0] a_dw, input logic a_rwe);
        rs = a_rs; rt = a_rt; re = a_re; rw = a_rw; dw = a_dw; rwe = a_rwe;
    endtask

    task automatic push3(input exp_t ea, input exp_t eb, input exp_t ec);
        q[0].push_back(ea);
        q[1].push_back(eb);
        q[2].push_back(ec);
    endtask

    // Drives the wide instance and advances its reference model (bypass on, no zero register).
    task automatic applyStimulus(input logic [4:0] a_rs, input logic [4:0] a_rt, input logic a_re,
                                 input logic [4:0] a_rw, input logic [31:0] a_dw, input logic a_rwe);
        rs32 = a_rs; rt32 = a_rt; re32 = a_re; rw32 = a_rw; dw32 = a_dw; rwe32 = a_rwe;
        if (a_re) begin
            mout.crs  = (a_rwe && a_rw == a_rs) ? a_dw : mmem[a_rs];
            mout.crt  = (a_rwe && a_rw == a_rt) ? a_dw : mmem[a_rt];
            mout.wcol = a_rwe && ((a_rw == a_rs) || (a_rw == a_rt));
        end
        if (a_rwe) mmem[a_rw] = a_dw;
        q[3].push_back(mout);
    endtask

    task automatic test_reset();
        exp_t e, o;
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        void'(q[3].pop_back());
        #1 rst_n = 1'b0;
        #2;
        for (int k = 0; k < 4; k++) begin
            o = obs(k);
            checks++;
            if (o !== '0) begin
                errors++;
                $display("[TB] FAIL reset_init dut%0d: got %h/%h/%b required 0/0/0", k, o.crs, o.crt, o.wcol);
            end
        end
        #9 rst_n = 1'b1;
        drive(0, 0, 0, 2, 4'hA, 1);
        tick();
        drive(2, 3, 1, 0, 0, 0);
        push3(mk(32'hA, 0, 0), mk(32'hA, 0, 0), mk(32'hA, 0, 0));
        tick();
        for (int k = 0; k < 3; k++) begin
            e = q[k].pop_front();
            o = obs(k);
            checks++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL reset_preread dut%0d: got %h/%h/%b required %h/%h/%b", k, o.crs, o.crt, o.wcol, e.crs, e.crt, e.wcol);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            o = obs(k);
            checks++;
            if (o !== '0) begin
                errors++;
                $display("[TB] FAIL reset_async dut%0d: got %h/%h/%b required 0/0/0", k, o.crs, o.crt, o.wcol);
            end
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        push3(mk(0, 0, 0), mk(0, 0, 0), mk(0, 0, 0));
        tick();
        for (int k = 0; k < 3; k++) begin
            e = q[k].pop_front();
            o = obs(k);
            checks++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL reset_cleared dut%0d: got %h/%h/%b required %h/%h/%b", k, o.crs, o.crt, o.wcol, e.crs, e.crt, e.wcol);
            end
        end
    endtask

    task automatic test_write_read();
        exp_t e, o;
        drive(0, 0, 0, 1, 4'h5, 1); tick();
        drive(0, 0, 0, 2, 4'hC, 1); tick();
        drive(0, 0, 0, 3, 4'hF, 1); tick();
        drive(1, 3, 1, 0, 0, 0);
        push3(mk(5, 32'hF, 0), mk(5, 32'hF, 0), mk(5, 32'hF, 0));
        tick();
        drive(2, 2, 0, 0, 0, 0);
        push3(mk(5, 32'hF, 0), mk(5, 32'hF, 0), mk(5, 32'hF, 0));
        for (int n = 0; n < 2; n++) begin
            if (n == 1) tick();
            for (int k = 0; k < 3; k++) begin
                e = q[k].pop_front();
                o = obs(k);
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("[TB] FAIL write_read%0d dut%0d: got %h/%h/%b required %h/%h/%b", n, k, o.crs, o.crt, o.wcol, e.crs, e.crt, e.wcol);
                end
            end
        end
    endtask

    task automatic test_bypass();
        exp_t e, o;
        drive(2, 1, 1, 2, 4'h7, 1);
        push3(mk(7, 5, 1), mk(32'hC, 5, 1), mk(7, 5, 1));
        tick();
        drive(2, 1, 1, 0, 0, 0);
        push3(mk(7, 5, 0), mk(7, 5, 0), mk(7, 5, 0));
        for (int n = 0; n < 2; n++) begin
            if (n == 1) tick();
            for (int k = 0; k < 3; k++) begin
                e = q[k].pop_front();
                o = obs(k);
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("[TB] FAIL bypass%0d dut%0d: got %h/%h/%b required %h/%h/%b", n, k, o.crs, o.crt, o.wcol, e.crs, e.crt, e.wcol);
                end
            end
        end
    endtask

    task automatic test_zero_reg();
        exp_t e, o;
        for (int n = 0; n < 4; n++) begin
            case (n)
                0: begin
                    drive(0, 0, 1, 0, 4'h9, 1);
                    push3(mk(9, 9, 1), mk(0, 0, 1), mk(0, 0, 0));
                end
                1: begin
                    drive(0, 1, 1, 1, 4'h6, 1);
                    push3(mk(9, 6, 1), mk(9, 5, 1), mk(0, 6, 1));
                end
                2: begin
                    drive(3, 3, 0, 3, 4'h2, 1);
                    push3(mk(9, 6, 1), mk(9, 5, 1), mk(0, 6, 1));
                end
                default: begin
                    drive(0, 3, 1, 0, 0, 0);
                    push3(mk(9, 2, 0), mk(9, 2, 0), mk(0, 2, 0));
                end
            endcase
            tick();
            for (int k = 0; k < 3; k++) begin
                e = q[k].pop_front();
                o = obs(k);
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("[TB] FAIL zero_reg%0d dut%0d: got %h/%h/%b required %h/%h/%b", n, k, o.crs, o.crt, o.wcol, e.crs, e.crt, e.wcol);
                end
            end
        end
    endtask

    task automatic test_scaling();
        exp_t e, o;
        for (int i = 0; i < 32; i++) mmem[i] = '0;
        mout = '0;
        for (int n = 0; n < 1003; n++) begin
            if (n == 0) applyStimulus(0, 0, 0, 31, 32'hDEADBEEF, 1);
            else if (n == 1) applyStimulus(0, 0, 0, 16, 32'h1, 1);
            else if (n == 2) applyStimulus(31, 16, 1, 0, 0, 0);
            else begin
                logic [4:0] ars, art, arw;
                ars = 5'($urandom_range(0, 31));
                art = 5'($urandom_range(0, 31));
                arw = ($urandom_range(0, 3) == 0) ? ars : 5'($urandom_range(0, 31));
                applyStimulus(ars, art, 1'($urandom_range(0, 1)), arw, $urandom, 1'($urandom_range(0, 1)));
            end
            tick();
            e = q[3].pop_front();
            o = obs(3);
            if (n == 2 && e !== mk(32'hDEADBEEF, 1, 0)) begin
                errors++;
                $display("[TB] FAIL scaling_model: got %h/%h/%b required deadbeef/00000001/0", e.crs, e.crt, e.wcol);
            end
            checks++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL scaling%0d: got %h/%h/%b required %h/%h/%b", n, o.crs, o.crt, o.wcol, e.crs, e.crt, e.wcol);
            end
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        void'(q[3].pop_back());
    endtask

    task automatic test_reset_mid();
        exp_t e, o;
        drive(1, 2, 1, 1, 4'hD, 1);
        applyStimulus(31, 16, 1, 31, 32'h12345678, 1);
        void'(q[3].pop_back());
        #2 rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            o = obs(k);
            checks++;
            if (o !== '0) begin
                errors++;
                $display("[TB] FAIL reset_mid_async dut%0d: got %h/%h/%b required 0/0/0", k, o.crs, o.crt, o.wcol);
            end
        end
        for (int i = 0; i < 32; i++) mmem[i] = '0;
        mout = '0;
        for (int n = 0; n < 2; n++) begin
            if (n == 0) drive(1, 2, 1, 0, 0, 0);
            else        drive(0, 3, 1, 0, 0, 0);
            applyStimulus(5'(31 - n * 15), 5'(16 - n * 15), 1, 0, 0, 0);
            push3(mk(0, 0, 0), mk(0, 0, 0), mk(0, 0, 0));
            tick();
            for (int k = 0; k < 4; k++) begin
                e = q[k].pop_front();
                o = obs(k);
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("[TB] FAIL reset_mid%0d dut%0d: got %h/%h/%b required %h/%h/%b", n, k, o.crs, o.crt, o.wcol, e.crs, e.crt, e.wcol);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_reg();
        test_scaling();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_2r1w_param.md
Name: regfile_2r1w_param

Overview:
- Parametrised successor to the team's 4x4-bit, 2-read/1-write register file.
- Generalised in data width and depth.
- Adds synchronous registered read ports with read enable, write-to-read bypass, an optional hardwired-zero register 0, and asynchronous active-low reset of all storage.
- Sits between instruction decode (rs/rt/rw fields) and the ALU operand latches of the teaching datapath.

Parameters:
DW, 4, data width of each register in bits (>=1)
AW, 2, address width; DEPTH = 2**AW registers (AW>=1)
ZERO_R0, 0, 1 = register 0 reads as 0 and ignores writes; 0 = register 0 is ordinary
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return pre-write contents

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
rs  input  AW  read address, port S
rt  input  AW  read address, port T
re  input  1  read enable; 1 = update crs/crt this edge, 0 = hold
rw  input  AW  write address
dw  input  DW  write data
rwe  input  1  write enable
crs  output  DW  registered read data, port S
crt  output  DW  registered read data, port T
wcol  output  1  registered flag: last enabled read matched an active write address (bypass or stale-read event)

Behaviour:
- Reset (rst_n=0, asynchronous, independent of clk):
  - all DEPTH registers <= 0; crs, crt, wcol <= 0.
  - Held while rst_n=0; edges ignored.
  - First write accepted on the first rising edge with rst_n=1.
- Write, at rising edge:
  - if rwe=1, mem[rw] <= dw.
  - If ZERO_R0=1 and rw=0, the write is dropped; no state changes.
- Read, at rising edge, if re=1, for each port P in {S,T} with address a in {rs,rt}:
  - if ZERO_R0=1 and a=0: data = 0;
  - else if BYPASS=1 and rwe=1 and rw=a: data = dw;
  - else: data = mem[a], the value before this edge's write.
  - crs <= data(S); crt <= data(T).
- Read latency:
  - 1 cycle: address presented before edge N appears on crs/crt after edge N.
  - Outputs are stable between edges and independent of combinational address changes (no glitching as in the old mux).
- Read hold: re=0 -> crs, crt, wcol keep their values. Writes proceed regardless of re.
- wcol:
  - on edge with re=1: wcol <= rwe & ((rw=rs) | (rw=rt)) & ~(ZERO_R0 & rw=0).
  - on re=0: holds.
- Both ports may address the same register; both receive identical data.
- Only one write port exists, so there are no write-write conflicts.
- Addresses are always in range (DEPTH = 2**AW); no wrap-around handling needed.
- Storage: flip-flop array, DEPTH*DW bits. No X on outputs after reset. No combinational path from inputs to outputs.

Test Plan:
1. Reset/clear, defaults (DW=4, AW=2, ZERO_R0=0, BYPASS=1): write mem[2]=4'hA, assert rst_n=0 mid-cycle. Required: crs/crt=0 immediately without a clock edge. Release reset, then read rs=2, rt=3 with re=1 -> crs=0, crt=0 one edge later.
2. Write then read:
   - Write r1=4'h5, r2=4'hC, r3=4'hF on successive edges; then rs=1, rt=3, re=1 -> after the next edge crs=5, crt=F, wcol=0.
   - Same read with re=0 -> outputs unchanged.
3. Bypass:
   - Same edge: rwe=1, rw=2, dw=4'h7, rs=2, rt=1, re=1 (r2 previously C).
   - BYPASS=1 -> crs=7, crt=5, wcol=1.
   - Rerun with BYPASS=0 -> crs=C, wcol=1; next read of r2 -> 7.
4. Zero register, ZERO_R0=1: write rw=0, dw=4'h9; read rs=0, rt=0 -> crs=crt=0, wcol=0. Writes to r1 unaffected.
5. Width/depth scaling (DW=32, AW=5):
   - Write 32'hDEADBEEF to r31 and 32'h1 to r16.
   - Read rs=31, rt=16 -> exact values.
   - Random 1000-cycle write/read traffic checked against a reference model including bypass and hold rules.
6. Reset mid-operation: assert rst_n=0 for <1 cycle during a cycle with rwe=1, re=1. Required: the pending write is discarded, all registers read 0 afterwards, and wcol=0.
